vid_timing_ctrl: RTL and testbench

VID_TIMING_CTRL -- requirements
Module: vid_timing_ctrl

---
 rtl/vid_timing_ctrl.sv | 143 ++++++++++++++
 tb/tb_vid_timing_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_ctrl.sv
// Video timing generator: free-running h/v counters framed by an IDLE/RUN FSM,
// producing registered sync/data-enable/pixel outputs for a TMDS transmitter.
module vid_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        pixelclk,
  input  logic        rst,
  input  logic        en,
  input  logic        pattern_en,
  output logic        pix_req,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic [23:0] vid_pdata,
  output logic        vid_pvde,
  output logic        vid_phsync,
  output logic        vid_pvsync,
  output logic        frame_start,
  output logic        busy,
  output logic        underflow
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS     = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS     = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE     = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state, w_state_next;
  logic [11:0] r_h_cnt, r_v_cnt, w_h_next, w_v_next;
  logic        r_pat_mode, r_underflow, r_busy;
  logic        r_vid_pvde, r_vid_phsync, r_vid_pvsync, r_frame_start;
  logic [23:0] r_vid_pdata, w_pdata;
  logic        w_run, w_h_end, w_v_end, w_frame_first, w_active;
  logic        w_hs_region, w_vs_region, w_pat_mode;

  assign w_run         = (r_state == RUN);
  assign w_h_end       = (r_h_cnt == H_LAST);
  assign w_v_end       = (r_v_cnt == V_LAST);
  assign w_frame_first = w_run && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
  assign w_active      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_region   = (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
  assign w_vs_region   = (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);

  // Pattern mode is sampled on the first counter cycle of a frame and bypassed
  // there so that very first pixel already uses the new mode.
  assign w_pat_mode = w_frame_first ? pattern_en : r_pat_mode;

  // Handshake: pix_req is a same-cycle request with no backpressure; upstream
  // answers with pix_valid in that cycle, or the pixel is blanked and underflow set.
  assign pix_req = w_run && w_active;

  always_comb begin
    w_pdata = 24'h000000;
    if (pix_req) begin
      if (w_pat_mode)
        w_pdata = {r_h_cnt[7:0], r_v_cnt[7:0], r_h_cnt[7:0] ^ r_v_cnt[7:0]};
      else if (pix_valid)
        w_pdata = pix_data;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Stop requests only take effect at the last cycle of a frame.
  always_comb begin
    w_state_next = r_state;
    w_h_next     = r_h_cnt;
    w_v_next     = r_v_cnt;
    case (r_state)
      IDLE: begin
        w_h_next = 12'd0;
        w_v_next = 12'd0;
        if (en) w_state_next = RUN;
      end
      RUN: begin
        if (w_h_end) begin
          w_h_next = 12'd0;
          if (w_v_end) begin
            w_v_next = 12'd0;
            if (!en) w_state_next = IDLE;
          end else begin
            w_v_next = r_v_cnt + 12'd1;
          end
        end else begin
          w_h_next = r_h_cnt + 12'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (rst) begin
      r_h_cnt       <= 12'd0;
      r_v_cnt       <= 12'd0;
      r_pat_mode    <= 1'b0;
      r_underflow   <= 1'b0;
      r_busy        <= 1'b0;
      r_vid_pvde    <= 1'b0;
      r_vid_pdata   <= 24'h000000;
      r_vid_phsync  <= ~HS_POL;
      r_vid_pvsync  <= ~VS_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_pat_mode    <= w_pat_mode;
      r_underflow   <= r_underflow | (pix_req & ~pix_valid & ~w_pat_mode);
      r_busy        <= (w_state_next == RUN);
      r_vid_pvde    <= pix_req;
      r_vid_pdata   <= w_pdata;
      r_vid_phsync  <= (w_run && w_hs_region) ? HS_POL : ~HS_POL;
      r_vid_pvsync  <= (w_run && w_vs_region) ? VS_POL : ~VS_POL;
      r_frame_start <= w_frame_first;
    end
  end

  assign vid_pdata   = r_vid_pdata;
  assign vid_pvde    = r_vid_pvde;
  assign vid_phsync  = r_vid_phsync;
  assign vid_pvsync  = r_vid_pvsync;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_vid_timing_ctrl.sv
// Bench for vid_timing_ctrl on a small 14x7 raster: hand vectors, directed
// frame/stop/pattern/reset sequences, then random traffic against a position model.
module tb_vid_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;

  logic        pixelclk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, pattern_en = 1'b0, pix_valid = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        pix_req, vid_pvde, vid_phsync, vid_pvsync, frame_start, busy, underflow;
  logic [23:0] vid_pdata;

  always #5 pixelclk = ~pixelclk;

  vid_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HPOL), .VS_POL(VPOL)
  ) dut (
    .pixelclk(pixelclk), .rst(rst), .en(en), .pattern_en(pattern_en),
    .pix_req(pix_req), .pix_data(pix_data), .pix_valid(pix_valid),
    .vid_pdata(vid_pdata), .vid_pvde(vid_pvde), .vid_phsync(vid_phsync),
    .vid_pvsync(vid_pvsync), .frame_start(frame_start), .busy(busy),
    .underflow(underflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [29:0] exp_q[$];

  // Reference model: running flag plus linear position inside the frame.
  bit m_run = 1'b0;
  int m_pos = 0;
  bit m_pat = 1'b0;
  bit m_uf  = 1'b0;

  typedef struct {
    logic        rst, en, pat, valid;
    logic [23:0] data;
    logic        req;
    logic [29:0] exp;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [29:0] outs();
    return {vid_pdata, vid_pvde, vid_phsync, vid_pvsync, frame_start, busy, underflow};
  endfunction

  task automatic step(input logic i_rst, input logic i_en, input logic i_pat,
                      input logic i_valid, input logic [23:0] i_data);
    int h, v;
    bit act, pat, fs;
    logic hs, vs;
    logic [23:0] d;
    logic [29:0] e;
    rst = i_rst; en = i_en; pattern_en = i_pat; pix_valid = i_valid; pix_data = i_data;
    #1;
    h   = m_pos % HT;
    v   = m_pos / HT;
    act = m_run && (h < HA) && (v < VA);
    chk("pix_req", 32'(pix_req), 32'(act));
    if (i_rst) begin
      m_run = 1'b0; m_pos = 0; m_pat = 1'b0; m_uf = 1'b0;
      e = {24'h0, 1'b0, ~HPOL, ~VPOL, 1'b0, 1'b0, 1'b0};
    end else if (!m_run) begin
      m_run = i_en;
      m_pos = 0;
      e = {24'h0, 1'b0, ~HPOL, ~VPOL, 1'b0, i_en, m_uf};
    end else begin
      pat   = (m_pos == 0) ? i_pat : m_pat;
      m_pat = pat;
      d = 24'h0;
      if (act) d = pat ? {h[7:0], v[7:0], h[7:0] ^ v[7:0]} : (i_valid ? i_data : 24'h0);
      if (act && !i_valid && !pat) m_uf = 1'b1;
      fs = (m_pos == 0);
      hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
      vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
      m_pos++;
      if (m_pos == FT) begin
        m_pos = 0;
        if (!i_en) m_run = 1'b0;
      end
      e = {d, act, hs, vs, fs, m_run, m_uf};
    end
    exp_q.push_back(e);
    @(posedge pixelclk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    chk("outputs", 32'(outs()), 32'(e));
  endtask

  // Runs with en=1 until the model reaches pos; a missed target counts as a failure.
  task automatic advance_to(input int pos, input logic pat);
    int n;
    for (n = 0; n < 3 * FT && !(m_run && m_pos == pos); n++)
      step(1'b0, 1'b1, pat, 1'b1, 24'hA5A5A5);
    if (!(m_run && m_pos == pos)) begin
      total++; bad++;
      $display("FAIL advance_to: position %0d not reached (at %0d)", pos, m_pos);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k2, n_de, n_hs, n_vs, n;

    //             rst   en    pat   valid data          req   {pdata, de, hs, vs, fs, busy, uf}
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 24'hA5A5A5, 1'b0, {24'h000000, 6'b010000}};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hA5A5A5, 1'b0, {24'h000000, 6'b010000}};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5, 1'b0, {24'h000000, 6'b010010}};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5, 1'b1, {24'hA5A5A5, 6'b110110}};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5, 1'b1, {24'hA5A5A5, 6'b110010}};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'hA5A5A5, 1'b1, {24'h000000, 6'b110011}};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5, 1'b1, {24'hA5A5A5, 6'b110011}};
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 24'hA5A5A5, 1'b1, {24'h000000, 6'b010000}};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hA5A5A5, 1'b0, {24'h000000, 6'b010000}};

    // Clock/reset
    rst = 1'b1;
    repeat (2) @(posedge pixelclk);
    #1;

    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; en = vt[i].en; pattern_en = vt[i].pat;
      pix_valid = vt[i].valid; pix_data = vt[i].data;
      #1;
      chk($sformatf("vec%0d_req", i), 32'(pix_req), 32'(vt[i].req));
      @(posedge pixelclk);
      #1;
      cyc++;
      chk($sformatf("vec%0d_out", i), 32'(outs()), 32'(vt[i].exp));
    end

    // Continuous run: one full frame of output cycles examined.
    k1 = -1; k2 = -1; n_de = 0; n_hs = 0; n_vs = 0;
    for (int k = 0; k < 2 * FT + 2; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5);
      if (frame_start) begin
        if (k1 < 0) k1 = k;
        else if (k2 < 0) k2 = k;
      end
      if (k >= 1 && k <= FT) begin
        n_de += int'(vid_pvde);
        n_hs += int'(vid_phsync == 1'b0);
        n_vs += int'(vid_pvsync == 1'b1);
      end
    end
    chk("first_frame_start", 32'(k1), 32'd1);
    chk("frame_period", 32'(k2 - k1), 32'(FT));
    chk("pvde_per_frame", 32'(n_de), 32'(HA * VA));
    chk("hsync_low_per_frame", 32'(n_hs), 32'(HS * VT));
    chk("vsync_high_per_frame", 32'(n_vs), 32'(HT * VS));

    // Stop requested mid-frame, cancelled before the boundary.
    advance_to(HT + 3, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 24'h123456);
    advance_to(5, 1'b0);
    chk("cancelled_stop_busy", 32'(busy), 32'd1);

    // Stop requested at h=3, v=1 completes the frame.
    advance_to(HT + 3, 1'b0);
    n = 0;
    for (int k = 0; k < 2 * FT; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 24'h5A5A5A);
      n++;
      if (!busy) break;
    end
    chk("stop_len", 32'(n), 32'(FT - (HT + 3)));
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 24'hFFFFFF);
    chk("idle_outputs", 32'(outs()), {2'b00, 24'h000000, 6'b010000});
    step(1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5);
    chk("restart_frame_start", 32'(frame_start), 32'd1);

    // Pattern mode requested mid-frame only applies from the next frame.
    advance_to(2 * HT + 1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 24'hA5A5A5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 24'hA5A5A5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 24'hA5A5A5);
    chk("pattern_midframe", 32'(vid_pdata), 32'h00A5A5A5);
    advance_to(2 * HT + 3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 24'hA5A5A5);
    chk("pattern_h3_v2", 32'(vid_pdata), 32'h00030201);

    // Underflow is sticky across valid pixels until reset.
    advance_to(1, 1'b0);
    advance_to(2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'hA5A5A5);
    chk("underflow_pixel", 32'(vid_pdata), 32'h0);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5);
    chk("underflow_sticky", 32'(underflow), 32'd1);

    // Reset mid-frame aborts at once; restart gives a fresh frame.
    advance_to(2 * HT + 5, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 24'hA5A5A5);
    chk("rst_abort", 32'(outs()), {2'b00, 24'h000000, 6'b010000});
    step(1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5);
    chk("rst_restart_frame_start", 32'(frame_start), 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 1200; k++)
      step(1'(($urandom_range(0, 299) == 0)), 1'(($urandom_range(0, 15) != 0)),
           1'(($urandom_range(0, 2) == 0)), 1'(($urandom_range(0, 19) != 0)),
           24'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
